frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 109 ++++++++++
 tb/tb_frame_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: gates an upstream beat stream into fixed-length frames,
// marks frame boundaries and pilot beats, and counts completed frames.
module frame_sequencer #(
    parameter int CNT_W  = 13,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              valid,
    input  logic              ready,
    output logic              ready_up,
    input  logic [CNT_W-1:0]  frame_length,
    input  logic [CNT_W-1:0]  pilot_interval,
    input  logic [CNT_W-1:0]  pilot_len,
    output logic              start_frame,
    output logic              end_frame,
    output logic              frame_last,
    output logic              pilot_active,
    output logic [CNT_W-1:0]  sym_index,
    output logic [FCNT_W-1:0] frame_count,
    output logic              cfg_error
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  per_q;
    logic [CNT_W-1:0]  plen_q;
    logic [CNT_W-1:0]  phase;

    logic              first;
    logic              len_short;
    logic [CNT_W-1:0]  len_live;
    logic [CNT_W-1:0]  len_eff;
    logic [CNT_W-1:0]  per_eff;
    logic [CNT_W-1:0]  plen_eff;
    logic [CNT_W-1:0]  phase_cur;
    logic              last;
    logic              beat;

    // Until beat 0 is taken, the frame shape comes straight from the inputs;
    // frames shorter than two beats are stretched to two.
    assign first     = (sym_index == '0);
    assign len_short = (frame_length < CNT_W'(2));
    assign len_live  = len_short ? CNT_W'(2) : frame_length;
    assign len_eff   = first ? len_live       : len_q;
    assign per_eff   = first ? pilot_interval : per_q;
    assign plen_eff  = first ? pilot_len      : plen_q;
    assign phase_cur = first ? '0 : phase;
    assign last      = (sym_index == len_eff - CNT_W'(1));
    assign beat      = valid && ready_up;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (beat && last && !enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_up     = ready && ((state != IDLE) || enable);
        frame_last   = last;
        pilot_active = (per_eff != '0) && (phase_cur < plen_eff);
    end

    // Per-beat bookkeeping; reset abandons any frame in flight silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            per_q       <= '0;
            plen_q      <= '0;
            phase       <= '0;
            sym_index   <= '0;
            frame_count <= '0;
            start_frame <= 1'b0;
            end_frame   <= 1'b0;
            cfg_error   <= 1'b0;
        end else begin
            start_frame <= beat && first;
            end_frame   <= beat && last;
            if (beat) begin
                if (first) begin
                    len_q  <= len_live;
                    per_q  <= pilot_interval;
                    plen_q <= pilot_len;
                    if (len_short) cfg_error <= 1'b1;
                end
                phase <= (phase_cur == per_eff - CNT_W'(1)) ? '0 : phase_cur + CNT_W'(1);
                if (last) begin
                    sym_index   <= '0;
                    frame_count <= frame_count + FCNT_W'(1);
                end else begin
                    sym_index <= sym_index + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: framing, pilots, backpressure,
// enable drop, illegal length and mid-frame reset.
module tb_frame_sequencer;

    localparam int CNT_W  = 13;
    localparam int FCNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              valid = 1'b0;
    logic              ready = 1'b0;
    logic              ready_up;
    logic [CNT_W-1:0]  frame_length = '0;
    logic [CNT_W-1:0]  pilot_interval = '0;
    logic [CNT_W-1:0]  pilot_len = '0;
    logic              start_frame;
    logic              end_frame;
    logic              frame_last;
    logic              pilot_active;
    logic [CNT_W-1:0]  sym_index;
    logic [FCNT_W-1:0] frame_count;
    logic              cfg_error;

    int checks = 0;
    int errors = 0;

    frame_sequencer #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .valid(valid), .ready(ready),
        .ready_up(ready_up), .frame_length(frame_length),
        .pilot_interval(pilot_interval), .pilot_len(pilot_len),
        .start_frame(start_frame), .end_frame(end_frame),
        .frame_last(frame_last), .pilot_active(pilot_active),
        .sym_index(sym_index), .frame_count(frame_count), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; valid = 1'b0; ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; valid = 1'b1; ready = 1'b1; frame_length = 13'd4;
        tick();
        checks++; if (sym_index !== 13'd0) begin errors++; $display("[TB] FAIL reset_sym got %0d exp 0", sym_index); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_fcnt got %0d exp 0", frame_count); end
        checks++; if (start_frame !== 1'b0 || end_frame !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got %b%b exp 00", start_frame, end_frame); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg got %b exp 0", cfg_error); end
        rst = 1'b0; enable = 1'b0;
        #1;
        checks++; if (ready_up !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready_up got %b exp 0", ready_up); end
        tick();
        checks++; if (sym_index !== 13'd0 || start_frame !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_beat got sym %0d start %b exp 0 0", sym_index, start_frame); end
    endtask

    task automatic test_basic();
        do_reset();
        frame_length = 13'd4; pilot_interval = 13'd0; pilot_len = 13'd0;
        enable = 1'b1; valid = 1'b1; ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            #1;
            checks++; if (frame_last !== (b % 4 == 3)) begin errors++; $display("[TB] FAIL basic_last beat %0d got %b exp %b", b, frame_last, (b % 4 == 3)); end
            checks++; if (pilot_active !== 1'b0) begin errors++; $display("[TB] FAIL basic_pilot beat %0d got %b exp 0", b, pilot_active); end
            tick();
            checks++; if (start_frame !== (b % 4 == 0)) begin errors++; $display("[TB] FAIL basic_start beat %0d got %b exp %b", b, start_frame, (b % 4 == 0)); end
            checks++; if (end_frame !== (b % 4 == 3)) begin errors++; $display("[TB] FAIL basic_end beat %0d got %b exp %b", b, end_frame, (b % 4 == 3)); end
            checks++; if (sym_index !== 13'((b + 1) % 4)) begin errors++; $display("[TB] FAIL basic_sym beat %0d got %0d exp %0d", b, sym_index, (b + 1) % 4); end
        end
        checks++; if (frame_count !== 16'd3) begin errors++; $display("[TB] FAIL basic_fcnt got %0d exp 3", frame_count); end
    endtask

    task automatic test_pilot();
        do_reset();
        frame_length = 13'd10; pilot_interval = 13'd5; pilot_len = 13'd2;
        enable = 1'b1; valid = 1'b1; ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            automatic int m = b % 10;
            automatic logic exp_p = (m == 0) || (m == 1) || (m == 5) || (m == 6);
            #1;
            checks++; if (pilot_active !== exp_p) begin errors++; $display("[TB] FAIL pilot beat %0d got %b exp %b", b, pilot_active, exp_p); end
            checks++; if (frame_last !== (m == 9)) begin errors++; $display("[TB] FAIL pilot_last beat %0d got %b exp %b", b, frame_last, (m == 9)); end
            tick();
        end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("[TB] FAIL pilot_fcnt got %0d exp 2", frame_count); end
    endtask

    task automatic test_ready_toggle();
        int k;
        do_reset();
        frame_length = 13'd6; pilot_interval = 13'd0; pilot_len = 13'd0;
        enable = 1'b1; valid = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            automatic logic r = (c % 2 == 0);
            automatic logic exp_s = r && (k % 6 == 0);
            automatic logic exp_e = r && (k % 6 == 5);
            ready = r;
            #1;
            checks++; if (ready_up !== r) begin errors++; $display("[TB] FAIL toggle_ready_up cyc %0d got %b exp %b", c, ready_up, r); end
            tick();
            if (r) k++;
            checks++; if (start_frame !== exp_s) begin errors++; $display("[TB] FAIL toggle_start cyc %0d got %b exp %b", c, start_frame, exp_s); end
            checks++; if (end_frame !== exp_e) begin errors++; $display("[TB] FAIL toggle_end cyc %0d got %b exp %b", c, end_frame, exp_e); end
            checks++; if (sym_index !== 13'(k % 6)) begin errors++; $display("[TB] FAIL toggle_sym cyc %0d got %0d exp %0d", c, sym_index, k % 6); end
        end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("[TB] FAIL toggle_fcnt got %0d exp 1", frame_count); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        frame_length = 13'd8; pilot_interval = 13'd0; pilot_len = 13'd0;
        enable = 1'b1; valid = 1'b1; ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (b == 2) enable = 1'b0;
            #1;
            checks++; if (ready_up !== 1'b1) begin errors++; $display("[TB] FAIL drop_ready_up beat %0d got %b exp 1", b, ready_up); end
            tick();
            checks++; if (end_frame !== (b == 7)) begin errors++; $display("[TB] FAIL drop_end beat %0d got %b exp %b", b, end_frame, (b == 7)); end
        end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("[TB] FAIL drop_fcnt got %0d exp 1", frame_count); end
        checks++; if (ready_up !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle_ready_up got %b exp 0", ready_up); end
        tick();
        checks++; if (sym_index !== 13'd0 || start_frame !== 1'b0 || end_frame !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle got sym %0d start %b end %b exp 0 0 0", sym_index, start_frame, end_frame); end
    endtask

    task automatic test_cfg_error();
        do_reset();
        frame_length = 13'd1; pilot_interval = 13'd0; pilot_len = 13'd0;
        enable = 1'b1; valid = 1'b1; ready = 1'b1;
        #1;
        checks++; if (frame_last !== 1'b0) begin errors++; $display("[TB] FAIL cfg_last0 got %b exp 0", frame_last); end
        tick();
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("[TB] FAIL cfg_set got %b exp 1", cfg_error); end
        checks++; if (sym_index !== 13'd1 || start_frame !== 1'b1) begin errors++; $display("[TB] FAIL cfg_beat0 got sym %0d start %b exp 1 1", sym_index, start_frame); end
        #1;
        checks++; if (frame_last !== 1'b1) begin errors++; $display("[TB] FAIL cfg_last1 got %b exp 1", frame_last); end
        tick();
        checks++; if (end_frame !== 1'b1 || sym_index !== 13'd0) begin errors++; $display("[TB] FAIL cfg_beat1 got end %b sym %0d exp 1 0", end_frame, sym_index); end
        frame_length = 13'd4;
        for (int b = 0; b < 4; b++) tick();
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("[TB] FAIL cfg_sticky got %b exp 1", cfg_error); end
        checks++; if (frame_count !== 16'd2 || sym_index !== 13'd0) begin errors++; $display("[TB] FAIL cfg_next got fcnt %0d sym %0d exp 2 0", frame_count, sym_index); end
        do_reset();
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("[TB] FAIL cfg_clear got %b exp 0", cfg_error); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        frame_length = 13'd8; pilot_interval = 13'd0; pilot_len = 13'd0;
        enable = 1'b1; valid = 1'b1; ready = 1'b1;
        for (int b = 0; b < 3; b++) tick();
        checks++; if (sym_index !== 13'd3) begin errors++; $display("[TB] FAIL mid_pre_sym got %0d exp 3", sym_index); end
        rst = 1'b1;
        tick();
        rst = 1'b0; enable = 1'b0; valid = 1'b0; ready = 1'b0;
        checks++; if (sym_index !== 13'd0) begin errors++; $display("[TB] FAIL mid_sym got %0d exp 0", sym_index); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_fcnt got %0d exp 0", frame_count); end
        checks++; if (end_frame !== 1'b0 || start_frame !== 1'b0) begin errors++; $display("[TB] FAIL mid_pulses got %b%b exp 00", start_frame, end_frame); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("[TB] FAIL mid_cfg got %b exp 0", cfg_error); end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_pilot();
        test_ready_toggle();
        test_enable_drop();
        test_cfg_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
